// File: rtl/icache_refill_master.sv
// I-cache line refill master: one miss -> one AXI INCR read burst -> one line.
// Optional watchdog enabled with `define ICACHE_REFILL_TIMEOUT_EN.
module icache_refill_master #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int LINE_BYTES     = 32,
    parameter int BEATS          = LINE_BYTES / 4,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    input  logic [AXI_ADDR_WIDTH-1:0] req_addr,
    output logic                      req_ready,
    output logic                      resp_valid,
    output logic [LINE_BYTES*8-1:0]   resp_data,
    output logic                      resp_err,
    output logic                      arvalid,
    input  logic                      arready,
    output logic [AXI_ADDR_WIDTH-1:0] araddr,
    output logic [7:0]                arlen,
    output logic [2:0]                arsize,
    output logic [1:0]                arburst,
    input  logic                      rvalid,
    output logic                      rready,
    input  logic [31:0]               rdata,
    input  logic                      rlast,
    input  logic [1:0]                rresp
);

    localparam int OFF = $clog2(LINE_BYTES);
    localparam int CW  = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_AR,
        S_R,
        S_DONE
    } state_t;

    state_t                      r_state;
    state_t                      w_next;
    logic [AXI_ADDR_WIDTH-1:0]   r_addr;
    logic [CW-1:0]               r_cnt;
    logic                        r_err;
    logic [BEATS-1:0][31:0]      r_line;

    logic w_req_hs;
    logic w_ar_hs;
    logic w_beat;
    logic w_last_cnt;
    logic w_r_end;
    logic w_tmo;
    logic w_tmo_abort;

    assign w_req_hs   = req_valid && req_ready;
    assign w_ar_hs    = (r_state == S_AR) && arready;
    assign w_beat     = (r_state == S_R) && rvalid;
    assign w_last_cnt = (r_cnt == CW'(BEATS - 1));
    assign w_r_end    = w_beat && (rlast || w_last_cnt);

`ifdef ICACHE_REFILL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_wdog;

    // Watchdog: restarts on each AR/R handshake, counts while waiting on AXI
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wdog <= '0;
        end else if (r_state == S_IDLE || w_ar_hs || w_beat) begin
            r_wdog <= '0;
        end else if (r_state == S_AR || r_state == S_R) begin
            r_wdog <= r_wdog + TW'(1);
        end
    end

    assign w_tmo = (r_wdog == TW'(TIMEOUT_CYCLES));
`else
    assign w_tmo = 1'b0;
`endif

    assign w_tmo_abort = w_tmo &&
        ((r_state == S_AR && !w_ar_hs) || (r_state == S_R && !w_r_end));

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: if (w_req_hs) w_next = S_AR;
            S_AR:   if (w_ar_hs || w_tmo_abort) w_next = S_R;
            S_R:    if (w_r_end || w_tmo_abort) w_next = S_DONE;
            S_DONE: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
        if (r_state == S_AR && w_tmo_abort) begin
            w_next = S_DONE;
        end
    end

    // Output decode from the registered state
    always_comb begin
        req_ready  = 1'b0;
        arvalid    = 1'b0;
        rready     = 1'b0;
        resp_valid = 1'b0;
        resp_err   = 1'b0;
        unique case (r_state)
            S_IDLE: req_ready = !rst;
            S_AR:   arvalid = 1'b1;
            S_R:    rready = 1'b1;
            S_DONE: begin
                resp_valid = 1'b1;
                resp_err   = r_err;
            end
            default: ;
        endcase
    end

    // Request latch, beat assembly and sticky error tracking
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr <= '0;
            r_cnt  <= '0;
            r_err  <= 1'b0;
            r_line <= '0;
        end else begin
            if (w_req_hs) begin
                r_addr <= {req_addr[AXI_ADDR_WIDTH-1:OFF], {OFF{1'b0}}};
                r_cnt  <= '0;
                r_err  <= 1'b0;
            end
            if (w_beat) begin
                r_line[r_cnt] <= rdata;
                r_cnt         <= r_cnt + CW'(1);
                // rlast disagreeing with the count only happens on the final beat
                if (rresp != 2'b00 || rlast != w_last_cnt) begin
                    r_err <= 1'b1;
                end
            end
            if (w_tmo_abort) begin
                r_err <= 1'b1;
            end
        end
    end

    assign araddr    = r_addr;
    assign arlen     = 8'(BEATS - 1);
    assign arsize    = 3'b010;
    assign arburst   = 2'b01;
    assign resp_data = r_line;

endmodule

// File: tb/tb_icache_refill_master.sv
// Directed bench for icache_refill_master (default 32-byte line, 8 beats).
// Table-driven bursts plus hand-written reset and watchdog sequences.
module tb_icache_refill_master;

    logic         clk = 1'b0;
    logic         rst;
    logic         req_valid;
    logic [31:0]  req_addr;
    logic         req_ready;
    logic         resp_valid;
    logic [255:0] resp_data;
    logic         resp_err;
    logic         arvalid;
    logic         arready;
    logic [31:0]  araddr;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         rvalid;
    logic         rready;
    logic [31:0]  rdata;
    logic         rlast;
    logic [1:0]   rresp;

    int checks = 0;
    int errors = 0;

    icache_refill_master dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .arvalid    (arvalid),
        .arready    (arready),
        .araddr     (araddr),
        .arlen      (arlen),
        .arsize     (arsize),
        .arburst    (arburst),
        .rvalid     (rvalid),
        .rready     (rready),
        .rdata      (rdata),
        .rlast      (rlast),
        .rresp      (rresp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] base;
        int          ar_wait;
        int          err_beat;
        int          rlast_beat;
        bit          hold;
        logic [31:0] exp_addr;
        bit          exp_err;
        int          exp_beats;
        logic [31:0] exp_w0;
        logic [31:0] exp_w7;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Drives one request and plays a simple AXI slave; entered at a negedge
    task automatic run_txn(input vec_t v);
        bit taken = 0;
        bit done  = 0;
        int stall = v.ar_wait;
        int beat  = 0;
        int ar_n  = 0;
        req_valid = 1'b1;
        req_addr  = v.addr;
        if (req_ready) taken = 1;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            if (taken && !v.hold) req_valid = 1'b0;
            if (req_valid && req_ready) taken = 1;
            arready = 1'b0;
            if (arvalid) begin
                chk("araddr", araddr, v.exp_addr);
                if (stall > 0) begin
                    stall--;
                end else begin
                    arready = 1'b1;
                    ar_n++;
                    chk("arlen", 32'(arlen), 32'd7);
                    chk("arsize", 32'(arsize), 32'd2);
                    chk("arburst", 32'(arburst), 32'd1);
                end
            end
            rvalid = 1'b0;
            rlast  = 1'b0;
            rresp  = 2'b00;
            if (rready) begin
                rvalid = 1'b1;
                rdata  = v.base + 32'(beat);
                rresp  = (beat == v.err_beat) ? 2'b10 : 2'b00;
                rlast  = (beat == v.rlast_beat);
                beat++;
            end
            if (resp_valid) begin
                done = 1;
                chk("resp_err", 32'(resp_err), 32'(v.exp_err));
                chk("word0", resp_data[31:0], v.exp_w0);
                chk("word7", resp_data[255:224], v.exp_w7);
                chk("ready_in_done", 32'(req_ready), 32'd0);
            end
        end
        chk("resp_seen", 32'(done), 32'd1);
        chk("ar_handshakes", 32'(ar_n), 32'd1);
        chk("beats", 32'(beat), 32'(v.exp_beats));
        @(negedge clk);
        chk("resp_pulse_1cyc", 32'(resp_valid), 32'd0);
        chk("ready_after_resp", 32'(req_ready), 32'd1);
        if (!v.hold) req_valid = 1'b0;
    endtask

    initial begin
        vecs[0] = '{32'h0000_0104, 32'h40, 0, -1, 7, 0,
                    32'h0000_0100, 0, 8, 32'h40, 32'h47};
        vecs[1] = '{32'h0000_03FF, 32'h100, 3, -1, 7, 0,
                    32'h0000_03E0, 0, 8, 32'h100, 32'h107};
        vecs[2] = '{32'h0000_0020, 32'h200, 0, 3, 7, 0,
                    32'h0000_0020, 1, 8, 32'h200, 32'h207};
        vecs[3] = '{32'h0000_0044, 32'h300, 0, -1, 5, 0,
                    32'h0000_0040, 1, 6, 32'h300, 32'h207};
        vecs[4] = '{32'h1000_0010, 32'h500, 1, 7, 7, 0,
                    32'h1000_0000, 1, 8, 32'h500, 32'h507};
        vecs[5] = '{32'h0000_0060, 32'h600, 0, -1, 99, 0,
                    32'h0000_0060, 1, 8, 32'h600, 32'h607};
        vecs[6] = '{32'h0000_0000, 32'h700, 0, -1, 7, 1,
                    32'h0000_0000, 0, 8, 32'h700, 32'h707};
        vecs[7] = '{32'h0000_0020, 32'h800, 2, -1, 7, 0,
                    32'h0000_0020, 0, 8, 32'h800, 32'h807};

        rst       = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        arready   = 1'b0;
        rvalid    = 1'b0;
        rdata     = '0;
        rlast     = 1'b0;
        rresp     = 2'b00;

        repeat (2) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_arvalid", 32'(arvalid), 32'd0);
        chk("rst_rready", 32'(rready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_araddr", araddr, 32'd0);
        chk("rst_data", 32'(|resp_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 8; i++) begin
            run_txn(vecs[i]);
        end

        // Reset in the middle of a burst: abandon it with no response
        begin
            int beats = 0;
            bit hit = 0;
            req_valid = 1'b1;
            req_addr  = 32'h0000_0040;
            for (int c = 0; c < 50 && beats < 2; c++) begin
                @(negedge clk);
                if (!req_ready) req_valid = 1'b0;
                arready = arvalid;
                rvalid  = 1'b0;
                if (rready) begin
                    rvalid = 1'b1;
                    rdata  = 32'h900 + 32'(beats);
                    beats++;
                end
            end
            @(negedge clk);
            chk("mid_in_r", 32'(rready), 32'd1);
            rvalid    = 1'b0;
            req_valid = 1'b0;
            arready   = 1'b0;
            rst       = 1'b1;
            #1;
            chk("mr_req_ready", 32'(req_ready), 32'd0);
            chk("mr_rready", 32'(rready), 32'd0);
            chk("mr_arvalid", 32'(arvalid), 32'd0);
            chk("mr_resp_valid", 32'(resp_valid), 32'd0);
            chk("mr_resp_err", 32'(resp_err), 32'd0);
            chk("mr_araddr", araddr, 32'd0);
            chk("mr_data", 32'(|resp_data), 32'd0);
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                if (resp_valid) hit = 1;
            end
            rst = 1'b0;
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                if (resp_valid) hit = 1;
            end
            chk("mr_no_resp", 32'(hit), 32'd0);
            chk("mr_idle_ready", 32'(req_ready), 32'd1);
        end

`ifdef ICACHE_REFILL_TIMEOUT_EN
        // Slave accepts the address but never returns data
        begin
            int in_r = 0;
            bit seen = 0;
            req_valid = 1'b1;
            req_addr  = 32'h0000_0200;
            for (int c = 0; c < 400 && !seen; c++) begin
                @(negedge clk);
                if (!req_ready) req_valid = 1'b0;
                arready = arvalid;
                if (rready) in_r++;
                if (resp_valid) begin
                    seen = 1;
                    chk("tmo_err", 32'(resp_err), 32'd1);
                end
            end
            chk("tmo_seen", 32'(seen), 32'd1);
            chk("tmo_r_cycles", 32'(in_r >= 256 && in_r <= 258), 32'd1);
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
